// File: rtl/fir_pkg.sv
// Shared FIR datapath widths, used by the MAC chain and the output quantizer.
package fir_pkg;

    localparam int unsigned FIR_ACC_WIDTH    = 33;
    localparam int unsigned FIR_OUT_WIDTH    = 16;
    localparam int unsigned FIR_FRAC_BITS    = 15;
    localparam int unsigned FIR_SATCNT_WIDTH = 16;

endpackage

// File: rtl/fir_skid_buf.sv
// Two-entry output skid buffer with a registered upstream ready.
// s_ready_o is low only when both entries are occupied.
module fir_skid_buf #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             push_c, pop_c;

    // Next-state: entry 0 is always the head; entry 1 only fills when the head is busy.
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        push_c  = s_valid_i && ready_q;
        pop_c   = valid_q && m_ready_i;
        unique case ({push_c, pop_c})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d = s_data_i;
                end else begin
                    ent1_d = s_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = s_data_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = s_data_i;
                end
            end
            default: begin
            end
        endcase
        ready_d = (count_d != 2'd2);
        valid_d = (count_d != 2'd0);
    end

    // State register; reset leaves the buffer empty and not ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = valid_q;
    assign m_data_o  = ent0_q;

endmodule

// File: rtl/fir_out_quant.sv
// FIR output quantizer: round-half-up by SHIFT bits, saturate to OUT_WIDTH,
// then a 2-entry skid buffer toward the consumer. Tracks saturation events.
// Optional macro FIR_OUT_QUANT_SATCNT_EN adds the sat_count port and counter.
module fir_out_quant
    import fir_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = FIR_ACC_WIDTH,
    parameter int unsigned OUT_WIDTH = FIR_OUT_WIDTH,
    parameter int unsigned SHIFT     = FIR_FRAC_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    input  logic                        out_ready,
    input  logic                        ovf_clr,
    output logic                        ovf_sticky
`ifdef FIR_OUT_QUANT_SATCNT_EN
    ,
    output logic [FIR_SATCNT_WIDTH-1:0] sat_count
`endif
);

    localparam int unsigned RW = IN_WIDTH + 1;
    localparam int unsigned SW = OUT_WIDTH + 1;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [RW-1:0]  ext_c, rnd_c;
    logic signed [RW-1:0]  st1_rnd_q, st1_rnd_d;
    logic                  st1_v_q, st1_v_d;
    logic [RW-OUT_WIDTH:0] hi_c;
    logic                  sat_c;
    logic [OUT_WIDTH-1:0]  qdata_c;
    logic [SW-1:0]         head_c;
    logic                  head_sat_c;
    logic                  xfer_sat_c;
    logic                  ovf_q, ovf_d;

    // One extra bit so adding the rounding half never loses the carry.
    assign ext_c = {in_data[IN_WIDTH-1], in_data};

    generate
        if (SHIFT == 0) begin : g_bypass
            assign rnd_c = ext_c;
        end else begin : g_round
            localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
            logic signed [RW-1:0] sum_c;
            assign sum_c = ext_c + $signed(HALF);
            assign rnd_c = sum_c >>> SHIFT;
        end
    endgenerate

    // Stage 1 advances whenever the skid buffer can take its current content.
    always_comb begin
        st1_v_d   = st1_v_q;
        st1_rnd_d = st1_rnd_q;
        if (in_ready) begin
            st1_v_d = in_valid;
            if (in_valid) begin
                st1_rnd_d = rnd_c;
            end
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st1_v_q   <= 1'b0;
            st1_rnd_q <= '0;
        end else begin
            st1_v_q   <= st1_v_d;
            st1_rnd_q <= st1_rnd_d;
        end
    end

    // Saturation: the value fits when every bit above the output sign bit matches it.
    always_comb begin
        hi_c    = st1_rnd_q[RW-1:OUT_WIDTH-1];
        sat_c   = !((&hi_c) || !(|hi_c));
        qdata_c = st1_rnd_q[OUT_WIDTH-1:0];
        if (sat_c) begin
            qdata_c = st1_rnd_q[RW-1] ? OUT_MIN : OUT_MAX;
        end
    end

    fir_skid_buf #(
        .WIDTH(SW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_valid_i(st1_v_q),
        .s_data_i ({sat_c, qdata_c}),
        .s_ready_o(in_ready),
        .m_valid_o(out_valid),
        .m_data_o (head_c),
        .m_ready_i(out_ready)
    );

    assign out_data   = head_c[OUT_WIDTH-1:0];
    assign head_sat_c = head_c[OUT_WIDTH];
    assign xfer_sat_c = out_valid && out_ready && head_sat_c;

    // Sticky overflow: a saturated transfer wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (xfer_sat_c) begin
            ovf_d = 1'b1;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;

`ifdef FIR_OUT_QUANT_SATCNT_EN
    logic [FIR_SATCNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating event counter; clear plus increment in one cycle yields 1.
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr) begin
            cnt_d = '0;
        end
        if (xfer_sat_c) begin
            if (ovf_clr) begin
                cnt_d = FIR_SATCNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + FIR_SATCNT_WIDTH'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
`endif

endmodule
